// File: rtl/matrix_pkg.sv
// Shared constants, loader state encoding and element addressing for the
// matrix loader and the multiplier core.
package matrix_pkg;

  localparam int DEF_X_DIM  = 2;
  localparam int DEF_Y_DIM  = 2;
  localparam int DEF_ELEM_W = 8;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_e;

  // Bit offset of flat element index idx in a bus of w-bit elements.
  function automatic int unsigned elem_offset(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Element stream in, operand pair out. The loader is the slave side;
// the stream source / operand consumer is the master side.
interface matrix_loader_if
  import matrix_pkg::*;
#(
  parameter int N      = DEF_X_DIM * DEF_Y_DIM,
  parameter int ELEM_W = DEF_ELEM_W
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ELEM_W-1:0]     in_data;
  logic                  in_last;
  logic [N*ELEM_W-1:0]   mat_a;
  logic [N*ELEM_W-1:0]   mat_b;
  logic                  mats_valid;
  logic                  mats_ack;
  logic                  frame_err;

  modport master (
    output in_valid, in_data, in_last, mats_ack,
    input  in_ready, mat_a, mat_b, mats_valid, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last, mats_ack,
    output in_ready, mat_a, mat_b, mats_valid, frame_err
  );
endinterface

// File: rtl/matrix_bank.sv
// N-entry register file with single indexed write port and flat read-out.
module matrix_bank
  import matrix_pkg::*;
#(
  parameter int N      = 4,
  parameter int ELEM_W = 8,
  parameter int IDX_W  = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                we,
  input  logic [IDX_W-1:0]    idx,
  input  logic [ELEM_W-1:0]   wdata,
  output logic [N*ELEM_W-1:0] rdata
);
  localparam int OFF_W = (N * ELEM_W > 1) ? $clog2(N * ELEM_W) : 1;

  logic [N*ELEM_W-1:0] mem_q, mem_d;
  logic [OFF_W-1:0]    off;

  always_comb begin
    off   = OFF_W'(elem_offset(32'(idx), ELEM_W));
    mem_d = mem_q;
    if (we) mem_d[off +: ELEM_W] = wdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign rdata = mem_q;
endmodule

// File: rtl/matrix_loader.sv
// Fills operand A then B from a serial element stream, checks in_last framing
// and holds the pair for the multiplier until it is acknowledged.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int X_DIM  = DEF_X_DIM,
  parameter int Y_DIM  = DEF_Y_DIM,
  parameter int ELEM_W = DEF_ELEM_W
) (
  input  logic           CLK,
  input  logic           RST,
  matrix_loader_if.slave bus
);
  localparam int N     = X_DIM * Y_DIM;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             acc, last_idx, we_a, we_b;

  // Gated by RST so nothing is offered while reset is held.
  assign bus.in_ready   = (state_q != FULL) && !RST;
  assign bus.mats_valid = (state_q == FULL);
  assign bus.frame_err  = err_q;
  assign acc            = bus.in_valid && bus.in_ready;
  assign last_idx       = (idx_q == IDX_W'(N - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    we_a    = 1'b0;
    we_b    = 1'b0;
    case (state_q)
      LOAD_A: if (acc) begin
        we_a = 1'b1;
        if (bus.in_last) begin
          err_d = 1'b1;
          idx_d = '0;
        end else if (last_idx) begin
          state_d = LOAD_B;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      LOAD_B: if (acc) begin
        we_b = 1'b1;
        if (last_idx) begin
          idx_d = '0;
          if (bus.in_last) begin
            state_d = FULL;
          end else begin
            err_d   = 1'b1;
            state_d = LOAD_A;
          end
        end else if (bus.in_last) begin
          err_d   = 1'b1;
          state_d = LOAD_A;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      FULL: if (bus.mats_ack) state_d = LOAD_A;
      default: begin
        state_d = LOAD_A;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  matrix_bank #(.N(N), .ELEM_W(ELEM_W), .IDX_W(IDX_W)) u_bank_a (
    .CLK(CLK), .RST(RST), .we(we_a), .idx(idx_q), .wdata(bus.in_data), .rdata(bus.mat_a)
  );

  matrix_bank #(.N(N), .ELEM_W(ELEM_W), .IDX_W(IDX_W)) u_bank_b (
    .CLK(CLK), .RST(RST), .we(we_b), .idx(idx_q), .wdata(bus.in_data), .rdata(bus.mat_b)
  );
endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: the driver feeds a frame-level model
// that queues expected operand pairs / framing errors; a monitor checks them.
module tb_matrix_loader;
  import matrix_pkg::*;

  localparam int N = DEF_X_DIM * DEF_Y_DIM;
  localparam int W = DEF_ELEM_W;

  typedef struct {
    bit             is_err;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    int             cyc;
  } ev_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  matrix_loader_if #(.N(N), .ELEM_W(W)) bus ();
  matrix_loader dut (.CLK(CLK), .RST(RST), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  ev_t        exp_q[$];
  logic [W-1:0] cur[$];
  bit         m_full = 1'b0;
  logic [W-1:0] fv [2*N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int base);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = cur[base + i];
    return r;
  endfunction

  // Frame rule: a frame is exactly 2N accepted elements with in_last on the last one.
  function automatic void model_accept(input logic [W-1:0] d, input logic l);
    ev_t e;
    cur.push_back(d);
    e.cyc = cyc;
    e.a = '0;
    e.b = '0;
    if (cur.size() == 2 * N) begin
      e.is_err = !l;
      if (l) begin
        e.a = pack(0);
        e.b = pack(N);
        m_full = 1'b1;
      end
      exp_q.push_back(e);
      cur.delete();
    end else if (l) begin
      e.is_err = 1'b1;
      exp_q.push_back(e);
      cur.delete();
    end
  endfunction

  // One clock: called at a negedge, returns at the next negedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic l, input logic ack);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.mats_ack = ack;
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(!m_full));
    @(posedge CLK);
    #1;
    if (m_full) begin
      if (ack) m_full = 1'b0;
    end else if (v) begin
      model_accept(d, l);
    end
    @(negedge CLK);
  endtask

  task automatic send_frame(input int cnt, input int lastpos, input bit gaps, input int ack_first);
    for (int i = 0; i < cnt; i++) begin
      if (gaps) begin
        for (int g = 0; g < 4 && $urandom_range(0, 2) == 0; g++)
          step(1'b0, W'($urandom), 1'($urandom), 1'($urandom));
      end
      step(1'b1, fv[i], 1'(i == lastpos), 1'(i < ack_first));
    end
  endtask

  task automatic release_full(input int hold);
    repeat (hold) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("valid_after_ack", 64'(bus.mats_valid), 64'd0);
  endtask

  task automatic check_mats(input string nm, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    chk({nm, "_valid"}, 64'(bus.mats_valid), 64'd1);
    chk({nm, "_a"}, 64'(bus.mat_a), 64'(a));
    chk({nm, "_b"}, 64'(bus.mat_b), 64'(b));
  endtask

  // Monitor: pops an expectation whenever the DUT presents a pair or an error.
  logic [N*W-1:0] hold_a, hold_b;
  bit prev_v = 1'b0, prev_e = 1'b0;
  always @(negedge CLK) begin
    if (RST) begin
      prev_v = 1'b0;
      prev_e = 1'b0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_event: got none expected %s at cycle %0d",
                 exp_q[0].is_err ? "frame_err" : "mats_valid", exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.mats_valid && !prev_v) begin
        tests++;
        if (exp_q.size() > 0 && !exp_q[0].is_err && exp_q[0].cyc == cyc) begin
          if (bus.mat_a !== exp_q[0].a || bus.mat_b !== exp_q[0].b) begin
            fails++;
            $display("FAIL operands: got a=%h b=%h expected a=%h b=%h",
                     bus.mat_a, bus.mat_b, exp_q[0].a, exp_q[0].b);
          end
          void'(exp_q.pop_front());
        end else begin
          fails++;
          $display("FAIL unexpected_valid: got mats_valid=1 expected 0 at cycle %0d", cyc);
        end
        hold_a = bus.mat_a;
        hold_b = bus.mat_b;
      end else if (bus.mats_valid) begin
        tests++;
        if (bus.mat_a !== hold_a || bus.mat_b !== hold_b) begin
          fails++;
          $display("FAIL stable: got a=%h b=%h expected a=%h b=%h",
                   bus.mat_a, bus.mat_b, hold_a, hold_b);
        end
      end
      if (bus.frame_err) begin
        tests++;
        if (!prev_e && exp_q.size() > 0 && exp_q[0].is_err && exp_q[0].cyc == cyc) begin
          void'(exp_q.pop_front());
        end else begin
          fails++;
          $display("FAIL unexpected_err: got frame_err=1 expected 0 at cycle %0d", cyc);
        end
      end
      prev_v = bus.mats_valid;
      prev_e = bus.frame_err;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.mats_ack = 1'b0;
    #12;
    chk("rst_mat_a", 64'(bus.mat_a), 64'd0);
    chk("rst_mat_b", 64'(bus.mat_b), 64'd0);
    chk("rst_valid", 64'(bus.mats_valid), 64'd0);
    chk("rst_err", 64'(bus.frame_err), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Clean frame 1..8, held full, then acked; ack stays high into next frame.
    for (int i = 0; i < 2 * N; i++) fv[i] = W'(i + 1);
    send_frame(2 * N, 2 * N - 1, 1'b0, 0);
    check_mats("frame1", 32'h04030201, 32'h08070605);
    release_full(5);
    for (int i = 0; i < 2 * N; i++) fv[i] = W'(i + 9);
    send_frame(2 * N, 2 * N - 1, 1'b0, 2);
    check_mats("frame2", 32'h0C0B0A09, 32'h100F0E0D);
    release_full(1);

    // Early last on B idx 1, then a clean frame.
    for (int i = 0; i < 2 * N; i++) fv[i] = W'(i + 1);
    send_frame(N + 2, N + 1, 1'b0, 0);
    for (int i = 0; i < 2 * N; i++) fv[i] = W'(i + 9);
    send_frame(2 * N, 2 * N - 1, 1'b0, 0);
    check_mats("after_early", 32'h0C0B0A09, 32'h100F0E0D);
    release_full(0);

    // Missing last, then a clean frame proves we restarted at A idx 0.
    for (int i = 0; i < 2 * N; i++) fv[i] = W'(8'h20 + i);
    send_frame(2 * N, -1, 1'b0, 0);
    chk("no_valid_after_missing", 64'(bus.mats_valid), 64'd0);
    for (int i = 0; i < 2 * N; i++) fv[i] = W'(8'h30 + i);
    send_frame(2 * N, 2 * N - 1, 1'b0, 0);
    check_mats("after_missing", 32'h33323130, 32'h37363534);
    release_full(2);

    // Alternating FF/00, gap-free then with gaps and stray acks.
    for (int i = 0; i < 2 * N; i++) fv[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
    send_frame(2 * N, 2 * N - 1, 1'b0, 0);
    check_mats("alt_nogap", 32'h00FF00FF, 32'h00FF00FF);
    release_full(0);
    send_frame(2 * N, 2 * N - 1, 1'b1, 0);
    check_mats("alt_gaps", 32'h00FF00FF, 32'h00FF00FF);
    release_full(1);

    // Asynchronous reset after 5 accepts.
    for (int i = 0; i < 2 * N; i++) fv[i] = W'(8'h40 + i);
    send_frame(5, -1, 1'b0, 0);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_a", 64'(bus.mat_a), 64'd0);
    chk("async_rst_b", 64'(bus.mat_b), 64'd0);
    chk("async_rst_ready", 64'(bus.in_ready), 64'd0);
    chk("async_rst_valid", 64'(bus.mats_valid), 64'd0);
    cur.delete();
    m_full = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 2 * N; i++) fv[i] = W'(8'h50 + i);
    send_frame(2 * N, 2 * N - 1, 1'b0, 0);
    check_mats("after_rst", 32'h53525150, 32'h57565554);
    release_full(0);

    // Random frames: clean, early-last or missing-last, with random gaps.
    for (int f = 0; f < 8; f++) begin
      int kind, p;
      kind = $urandom_range(0, 3);
      for (int i = 0; i < 2 * N; i++) fv[i] = W'($urandom);
      if (kind == 0) begin
        p = $urandom_range(0, 2 * N - 2);
        send_frame(p + 1, p, 1'b1, 0);
      end else if (kind == 1) begin
        send_frame(2 * N, -1, 1'b1, 0);
      end else begin
        send_frame(2 * N, 2 * N - 1, 1'b1, 0);
      end
      if (m_full) release_full($urandom_range(0, 4));
    end

    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
